demux_1to2_stream: RTL
======================

// Module: demux_1to2_stream
// PURPOSE
//   Registered 1-to-2 demultiplexer with valid/ready handshake on every port; the
//   steering counterpart of the datapath 2:1 selects. One 32-bit word in, routed by
//   in_sel to lane A (sel=0) or lane B (sel=1). Each lane has its own one-entry
//   output register, so the lanes drain independently.
//   Sits between a result producer and two consumers (e.g. regfile writeback / store
//   path) with per-lane delivered-word counters for debug.
// PARAMETERS
//   WIDTH  32  data width of in_data / outa_data / outb_data
//   CNT_W  16  width of per-lane delivered-word counters
// PORTS
//   clk         in   1      clock, all state updates on rising edge
//   rst_n       in   1      asynchronous active-low reset
//   flush       in   1      synchronous clear of both lane registers
//   in_data     in   WIDTH  input word
//   in_sel      in   1      destination: 0 = lane A, 1 = lane B
//   in_valid    in   1      input word present
//   in_ready    out  1      block accepts input this cycle
//   outa_data   out  WIDTH  lane A word
//   outa_valid  out  1      lane A word present
//   outa_ready  in   1      lane A consumer accepts
//   outb_data   out  WIDTH  lane B word
//   outb_valid  out  1      lane B word present
//   outb_ready  in   1      lane B consumer accepts
//   cnt_a       out  CNT_W  lane A completed transfers
//   cnt_b       out  CNT_W  lane B completed transfers
// BEHAVIOUR
//   - Reset: rst_n=0 asynchronously clears outa/outb_valid, outa/outb_data, cnt_a
//     and cnt_b to 0. In-flight words are discarded. Release on a clk edge.
//   - Lane X "free" = !outX_valid | outX_ready.
//   - in_ready = !flush & (in_sel ? freeB : freeA). This is combinational from
//     in_sel, flush and outX_ready. There is no path from in_valid to in_ready.
//   - Accept = in_valid & in_ready. On accept, the selected lane register loads
//     in_data and its valid is set at the next edge. Latency is 1 cycle.
//   - Drain: outX_valid & outX_ready clears outX_valid, unless the same edge
//     reloads lane X. If both happen, valid stays 1 with the new data. Full
//     throughput is 1 word/cycle per lane.
//   - The unselected lane is unaffected by input activity. It holds or drains
//     on its own.
//   - While outX_valid=1 & outX_ready=0, outX_data and outX_valid are held stable.
//   - flush=1: both valids clear at the next edge. Data registers and counters
//     are unchanged. in_ready=0 during the flush cycle, so nothing is accepted.
//     A drain handshake in the flush cycle still completes and is counted.
//   - cnt_X increments by 1 on each outX_valid & outX_ready. It wraps from
//     2^CNT_W-1 to 0 with no saturation.
//   - Upstream rule: once in_valid=1, hold in_data/in_sel until accepted. The
//     block does not check this.
//   - in_sel is ignored when in_valid=0. X on in_sel with in_valid=1 is illegal.
// TESTING
//   1 Reset: rst_n=0 mid-transfer with outa_valid=1 -> all outputs 0 immediately,
//     without waiting for clk.
//   2 Route: send 0xDEADBEEF sel=0, then 0x12345678 sel=1, both readies=1 ->
//     outa_data=0xDEADBEEF valid 1 cycle later, then outb likewise. cnt_a=cnt_b=1.
//   3 Backpressure: outa_ready=0, send 2 words sel=0 -> first word held; in_ready=0
//     for the second. A sel=1 word still passes to B.
//   4 Streaming: outa_ready=1, 8 back-to-back sel=0 words -> in_ready stays 1, 8
//     consecutive outa beats in order, cnt_a=8.
//   5 Flush: both lanes full, flush=1 with outb_ready=1 -> both valids 0 next cycle,
//     in_ready=0 that cycle, cnt_b+1, cnt_a unchanged.
//   6 Wrap: preload lane A to 0xFFFF transfers (CNT_W=16), one more beat ->
//     cnt_a=0x0000.

Source files
------------

// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream
//   Registered 1-to-2 stream demultiplexer. One input word is steered by in_sel to
//   lane A (sel=0) or lane B (sel=1). Each lane owns a one-entry output register,
//   so the lanes drain independently. Per-lane counters track delivered words.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous clear of both lane valids
//   in_data/in_sel/in_valid input word, destination lane, word present
//   in_ready                input accepted this cycle (no path from in_valid)
//   outa_*/outb_*           lane A / lane B valid/ready output streams
//   cnt_a, cnt_b            completed transfers per lane (wrapping)

module demux_1to2_stream #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] outa_data,
    output logic             outa_valid,
    input  logic             outa_ready,
    output logic [WIDTH-1:0] outb_data,
    output logic             outb_valid,
    input  logic             outb_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic [WIDTH-1:0] outa_data_q, outa_data_d;
    logic [WIDTH-1:0] outb_data_q, outb_data_d;
    logic             outa_valid_q, outa_valid_d;
    logic             outb_valid_q, outb_valid_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    logic free_a, free_b;
    logic accept, load_a, load_b;
    logic drain_a, drain_b;

    always_comb begin
        // A lane is free when empty or when its current word leaves this cycle.
        free_a   = !outa_valid_q | outa_ready;
        free_b   = !outb_valid_q | outb_ready;
        in_ready = !flush & (in_sel ? free_b : free_a);

        accept  = in_valid & in_ready;
        load_a  = accept & !in_sel;
        load_b  = accept & in_sel;
        drain_a = outa_valid_q & outa_ready;
        drain_b = outb_valid_q & outb_ready;

        outa_data_d = load_a ? in_data : outa_data_q;
        outb_data_d = load_b ? in_data : outb_data_q;

        // Flush wins; a reload on the same edge as a drain keeps the lane full.
        if (flush)        outa_valid_d = 1'b0;
        else if (load_a)  outa_valid_d = 1'b1;
        else if (drain_a) outa_valid_d = 1'b0;
        else              outa_valid_d = outa_valid_q;

        if (flush)        outb_valid_d = 1'b0;
        else if (load_b)  outb_valid_d = 1'b1;
        else if (drain_b) outb_valid_d = 1'b0;
        else              outb_valid_d = outb_valid_q;

        // Drains in the flush cycle still complete and are counted.
        cnt_a_d = cnt_a_q + CNT_W'(drain_a);
        cnt_b_d = cnt_b_q + CNT_W'(drain_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outa_data_q  <= '0;
            outb_data_q  <= '0;
            outa_valid_q <= 1'b0;
            outb_valid_q <= 1'b0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
        end else begin
            outa_data_q  <= outa_data_d;
            outb_data_q  <= outb_data_d;
            outa_valid_q <= outa_valid_d;
            outb_valid_q <= outb_valid_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
        end
    end

    assign outa_data  = outa_data_q;
    assign outb_data  = outb_data_q;
    assign outa_valid = outa_valid_q;
    assign outb_valid = outb_valid_q;
    assign cnt_a      = cnt_a_q;
    assign cnt_b      = cnt_b_q;

endmodule
